segment_fader: RTL and testbench
================================

Name: segment_fader

Overview:
- Parametrised successor to the per-pixel segment-enable lookup.
- Resolves the mask's segment ID to a multi-level intensity instead of a 1-bit enable, so LCD persistence (slow fade-out) is emulated per segment.
- Takes a flat live-segment vector, already mapped from the CPU-specific caches by an upstream mux, and snapshots it once per frame at vblank.
- Runs a per-segment level update sweep and serves pixel lookups through a fixed-latency pipeline into the video compositor.

Parameters:
- LINE_BITS, 4, width of segment line-select field.
- COL_BITS, 4, width of segment column field.
- ROW_BITS, 2, width of segment row field.
- FADE_BITS, 4, width of intensity level; MAX = 2^FADE_BITS-1.
- NUM_SEGS, 2^(LINE_BITS+COL_BITS+ROW_BITS), derived; not overridable.

Ports:
- clk  in  1  system video clock.
- reset_n  in  1  asynchronous, active-low reset.
- fade_en  in  1  1 = persistence enabled; 0 = binary on/off.
- fade_rise  in  FADE_BITS  level increment per frame while segment live.
- fade_fall  in  FADE_BITS  level decrement per frame while segment dark.
- seg_live  in  NUM_SEGS  live segment state, index = {line,col,row}.
- vblank_int  in  1  vertical blank.
- has_segment  in  1  mask reports current pixel belongs to a segment.
- segment_id  in  LINE_BITS+COL_BITS+ROW_BITS  {line,col,row} from mask.
- segment_level  out  FADE_BITS  intensity for current pixel, 2-cycle latency.
- segment_en  out  1  segment_level != 0, aligned with segment_level.
- sweep_busy  out  1  CLEAR or SWEEP in progress.
- overrun  out  1  sticky; vblank rose while SWEEP active.

Behaviour:
- Reset (async assert, sync release): state=CLEAR, index=0, snapshot=0, overrun=0; segment_level=0, segment_en=0, sweep_busy=1.
- Level store: NUM_SEGS x FADE_BITS dual-port RAM. Port A is the pixel read. Port B is the sweep read/write. RAM contents are not reset; CLEAR handles initialisation.
- FSM states: CLEAR, IDLE, SWEEP_RD, SWEEP_WR.
- CLEAR: writes 0 to index, index++ each cycle. After NUM_SEGS-1 -> IDLE.
- While in CLEAR, pixel outputs are forced 0.
- IDLE: vblank_int rising edge (registered previous-value detect) captures seg_live into snapshot, index=0 -> SWEEP_RD.
- SWEEP_RD: issue port B read at index -> SWEEP_WR.
- SWEEP_WR: compute the new level L' from old level L and s = snapshot[index], then write L'.
  - fade_en=0: L' = s ? MAX : 0.
  - fade_en=1, s=1: L' = min(L+fade_rise, MAX). Use a FADE_BITS+1 wide sum, then saturate.
  - fade_en=1, s=0: L' = (L < fade_fall) ? 0 : L-fade_fall.
  - Then: if index==NUM_SEGS-1 -> IDLE, else index++ -> SWEEP_RD.
- One sweep takes exactly 2*NUM_SEGS cycles (2048 at defaults).
- The sweep continues across the end of vblank. No abort.
- vblank rising edge during SWEEP_*: ignored (no re-snapshot); overrun <= 1. overrun clears only on reset.
- Pixel path:
  - Cycle N: segment_id and has_segment presented.
  - N+1: RAM read data and delayed has_segment available.
  - N+2: segment_level = has_segment_d ? level : 0; segment_en = |segment_level.
  - The path is fully pipelined: a new ID is accepted every cycle, with no stalls.
- Port A read and port B write to the same address in the same cycle: port A returns the old data (read-first). The pixel sees the new level the following frame at worst.
- snapshot is frozen outside the capture cycle, so seg_live changes mid-sweep have no effect.
- fade_rise/fade_fall/fade_en are sampled per segment in SWEEP_WR. Changing them mid-sweep is permitted; affected segments use the new value.
- fade_rise=0 with fade_en=1: a dark segment never lights. This is legal; no special case.

Decomposition:
- segments_pkg holds:
  - LINE_BITS/COL_BITS/ROW_BITS defaults;
  - the segment_id_t packed struct {line,col,row};
  - the fader_state_t enum {CLEAR, IDLE, SWEEP_RD, SWEEP_WR};
  - a saturating add/sub function.
- One sub-module, segment_level_ram: simple dual-port, read-first, registered read on both ports, parametrised depth/width. It infers BRAM.

Test Plan:
- Reset release: sweep_busy=1 for exactly 1024 cycles, then 0. segment_level=0 for any segment_id throughout.
- fade_en=0, seg_live[{2,3,1}]=1, vblank pulse, sweep done: has_segment=1, id {2,3,1} -> segment_level=15, segment_en=1 two cycles later. id {2,3,0} -> 0.
- fade_en=1, rise=15, fall=4. Segment lit for 1 frame, then dark: levels over successive frames 15, 11, 7, 3, 0, 0. segment_en drops on the frame level reaches 0.
- rise=6, segment held live: 6, 12, 15, 15 (saturation). has_segment=0 with the same ID -> level 0.
- Second vblank rising edge 500 cycles after the first (mid-sweep) -> overrun=1 and stays 1. Snapshot is unchanged and the sweep finishes at cycle 2048.
- Back-to-back pixel IDs every cycle during SWEEP_WR on the same address -> old level returned; outputs match a reference model with fixed 2-cycle latency.

Source files
------------

// File: rtl/segments_pkg.sv
// Shared types and helpers for the segment fader.
// Holds segment field widths, the segment id layout, fader states and level math.
package segments_pkg;

    localparam int LINE_BITS_DEF = 4;
    localparam int COL_BITS_DEF  = 4;
    localparam int ROW_BITS_DEF  = 2;
    localparam int FADE_BITS_DEF = 4;

    // Wide enough for any practical intensity width; callers cast down.
    localparam int SAT_W = 16;

    typedef struct packed {
        logic [LINE_BITS_DEF-1:0] line;
        logic [COL_BITS_DEF-1:0]  col;
        logic [ROW_BITS_DEF-1:0]  row;
    } segment_id_t;

    typedef enum logic [1:0] {
        CLEAR,
        IDLE,
        SWEEP_RD,
        SWEEP_WR
    } fader_state_t;

    // up=1: saturating add clamped at max_lvl; up=0: subtract floored at 0.
    function automatic logic [SAT_W-1:0] sat_step(
        input logic [SAT_W-1:0] lvl,
        input logic [SAT_W-1:0] step,
        input logic [SAT_W-1:0] max_lvl,
        input logic             up
    );
        logic [SAT_W:0] sum;
        sum = {1'b0, lvl} + {1'b0, step};
        if (up) begin
            return (sum > {1'b0, max_lvl}) ? max_lvl : sum[SAT_W-1:0];
        end
        return (lvl < step) ? '0 : lvl - step;
    endfunction

endpackage

// File: rtl/segment_level_ram.sv
// Simple dual-port level store, read-first, registered reads on both ports.
// Port A: read only (pixel). Port B: read/write (sweep), enable-gated.
module segment_level_ram #(
    parameter int ADDR_BITS = 10,
    parameter int WIDTH     = 4
) (
    input  logic                 clk,
    input  logic [ADDR_BITS-1:0] a_addr,
    output logic [WIDTH-1:0]     a_rdata,
    input  logic                 b_en,
    input  logic                 b_we,
    input  logic [ADDR_BITS-1:0] b_addr,
    input  logic [WIDTH-1:0]     b_wdata,
    output logic [WIDTH-1:0]     b_rdata
);

    localparam int DEPTH = 2 ** ADDR_BITS;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] a_rdata_q;
    logic [WIDTH-1:0] b_rdata_q;

    // Non-blocking write makes a same-cycle port A read see the old word.
    always_ff @(posedge clk) begin
        a_rdata_q <= mem_q[a_addr];
        if (b_en) begin
            if (b_we) begin
                mem_q[b_addr] <= b_wdata;
            end
            b_rdata_q <= mem_q[b_addr];
        end
    end

    assign a_rdata = a_rdata_q;
    assign b_rdata = b_rdata_q;

endmodule

// File: rtl/segment_fader.sv
// Per-segment LCD persistence: frame sweep of fade levels plus 2-cycle pixel lookup.
// In: fade controls, seg_live, vblank_int, pixel id. Out: level/en, sweep_busy, overrun.
module segment_fader
    import segments_pkg::*;
#(
    parameter  int LINE_BITS = LINE_BITS_DEF,
    parameter  int COL_BITS  = COL_BITS_DEF,
    parameter  int ROW_BITS  = ROW_BITS_DEF,
    parameter  int FADE_BITS = FADE_BITS_DEF,
    localparam int ID_BITS   = LINE_BITS + COL_BITS + ROW_BITS,
    localparam int NUM_SEGS  = 2 ** ID_BITS
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 fade_en,
    input  logic [FADE_BITS-1:0] fade_rise,
    input  logic [FADE_BITS-1:0] fade_fall,
    input  logic [NUM_SEGS-1:0]  seg_live,
    input  logic                 vblank_int,
    input  logic                 has_segment,
    input  logic [ID_BITS-1:0]   segment_id,
    output logic [FADE_BITS-1:0] segment_level,
    output logic                 segment_en,
    output logic                 sweep_busy,
    output logic                 overrun
);

    localparam logic [FADE_BITS-1:0] MAX_LVL = '1;

    fader_state_t         state_q, state_d;
    logic [ID_BITS-1:0]   index_q, index_d;
    logic [NUM_SEGS-1:0]  snap_q, snap_d;
    logic                 overrun_q, overrun_d;
    logic                 vb_prev_q, vb_prev_d;
    logic                 pix_vld_q, pix_vld_d;
    logic [FADE_BITS-1:0] level_q, level_d;

    logic                 vb_rise;
    logic                 seg_on;
    logic                 b_en;
    logic                 b_we;
    logic [FADE_BITS-1:0] b_wdata;
    logic [FADE_BITS-1:0] b_rdata;
    logic [FADE_BITS-1:0] a_rdata;

    segment_level_ram #(
        .ADDR_BITS(ID_BITS),
        .WIDTH    (FADE_BITS)
    ) u_ram (
        .clk    (clk),
        .a_addr (segment_id),
        .a_rdata(a_rdata),
        .b_en   (b_en),
        .b_we   (b_we),
        .b_addr (index_q),
        .b_wdata(b_wdata),
        .b_rdata(b_rdata)
    );

    always_comb begin
        state_d   = state_q;
        index_d   = index_q;
        snap_d    = snap_q;
        overrun_d = overrun_q;
        b_en      = 1'b0;
        b_we      = 1'b0;
        b_wdata   = '0;
        vb_rise   = vblank_int & ~vb_prev_q;
        vb_prev_d = vblank_int;
        seg_on    = snap_q[index_q];
        // RAM holds garbage until CLEAR finishes, so lookups are masked.
        pix_vld_d = has_segment & (state_q != CLEAR);
        level_d   = pix_vld_q ? a_rdata : '0;

        unique case (state_q)
            CLEAR: begin
                b_en    = 1'b1;
                b_we    = 1'b1;
                index_d = index_q + 1'b1;
                if (&index_q) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (vb_rise) begin
                    snap_d  = seg_live;
                    index_d = '0;
                    state_d = SWEEP_RD;
                end
            end
            SWEEP_RD: begin
                b_en    = 1'b1;
                state_d = SWEEP_WR;
            end
            SWEEP_WR: begin
                b_en = 1'b1;
                b_we = 1'b1;
                if (!fade_en) begin
                    b_wdata = seg_on ? MAX_LVL : '0;
                end else begin
                    b_wdata = FADE_BITS'(sat_step(
                        SAT_W'(b_rdata),
                        SAT_W'(seg_on ? fade_rise : fade_fall),
                        SAT_W'(MAX_LVL),
                        seg_on));
                end
                if (&index_q) begin
                    state_d = IDLE;
                end else begin
                    index_d = index_q + 1'b1;
                    state_d = SWEEP_RD;
                end
            end
            default: state_d = CLEAR;
        endcase

        if (vb_rise && (state_q == SWEEP_RD || state_q == SWEEP_WR)) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= CLEAR;
            index_q   <= '0;
            snap_q    <= '0;
            overrun_q <= 1'b0;
            vb_prev_q <= 1'b0;
            pix_vld_q <= 1'b0;
            level_q   <= '0;
        end else begin
            state_q   <= state_d;
            index_q   <= index_d;
            snap_q    <= snap_d;
            overrun_q <= overrun_d;
            vb_prev_q <= vb_prev_d;
            pix_vld_q <= pix_vld_d;
            level_q   <= level_d;
        end
    end

    assign segment_level = level_q;
    assign segment_en    = |level_q;
    assign sweep_busy    = (state_q != IDLE);
    assign overrun       = overrun_q;

endmodule

// File: tb/tb_segment_fader.sv
// Self-checking bench for segment_fader: behavioural level model plus directed frames.
// Drives inputs on negedge, model updates on posedge, compares every negedge.
module tb_segment_fader;
    import segments_pkg::*;

    localparam int ID_BITS  = 10;
    localparam int NUM_SEGS = 1024;
    localparam int MAXL     = 15;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic                fade_en = 1'b0;
    logic [3:0]          fade_rise = '0;
    logic [3:0]          fade_fall = '0;
    logic [NUM_SEGS-1:0] seg_live = '0;
    logic                vblank_int = 1'b0;
    logic                has_segment = 1'b0;
    logic [ID_BITS-1:0]  segment_id = '0;
    logic [3:0]          segment_level;
    logic                segment_en;
    logic                sweep_busy;
    logic                overrun;

    int total = 0;
    int bad = 0;
    bit rand_pix = 0;

    always #5 clk = ~clk;

    segment_fader dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .fade_en      (fade_en),
        .fade_rise    (fade_rise),
        .fade_fall    (fade_fall),
        .seg_live     (seg_live),
        .vblank_int   (vblank_int),
        .has_segment  (has_segment),
        .segment_id   (segment_id),
        .segment_level(segment_level),
        .segment_en   (segment_en),
        .sweep_busy   (sweep_busy),
        .overrun      (overrun)
    );

    // Behavioural model: mode 0=clearing, 1=idle, 2=sweeping.
    // Segment k is rewritten at the end of sweep cycle 2k+1.
    int                m_lev [NUM_SEGS];
    bit [NUM_SEGS-1:0] m_snap = '0;
    int                m_mode = 0;
    int                m_clr = 0;
    int                m_swc = 0;
    bit                m_vbp = 0;
    bit                m_ovr = 0;
    bit                p_vld = 0;
    int                p_val = 0;
    int                e_lev = 0;

    function automatic int next_level(bit s, int l);
        if (!fade_en) return s ? MAXL : 0;
        if (s) return (l + int'(fade_rise) > MAXL) ? MAXL : l + int'(fade_rise);
        return (l < int'(fade_fall)) ? 0 : l - int'(fade_fall);
    endfunction

    always @(posedge clk) begin
        if (!reset_n) begin
            m_mode = 0; m_clr = 0; m_swc = 0; m_snap = '0;
            m_vbp = 0; m_ovr = 0; p_vld = 0; p_val = 0; e_lev = 0;
        end else begin
            e_lev = p_vld ? p_val : 0;
            p_vld = has_segment && (m_mode != 0);
            p_val = m_lev[segment_id];
            if (vblank_int && !m_vbp && m_mode == 2) m_ovr = 1;
            case (m_mode)
                0: begin
                    m_clr++;
                    if (m_clr == NUM_SEGS) m_mode = 1;
                end
                1: begin
                    if (vblank_int && !m_vbp) begin
                        m_snap = seg_live;
                        m_swc = 0;
                        m_mode = 2;
                    end
                end
                default: begin
                    if (m_swc % 2 == 1)
                        m_lev[m_swc/2] = next_level(m_snap[m_swc/2], m_lev[m_swc/2]);
                    m_swc++;
                    if (m_swc == 2 * NUM_SEGS) m_mode = 1;
                end
            endcase
            m_vbp = vblank_int;
        end
    end

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("busy", sweep_busy, int'(m_mode != 1));
        check("level", segment_level, e_lev);
        check("en", segment_en, int'(e_lev != 0));
        check("overrun", overrun, int'(m_ovr));
    end

    function automatic int sid(int l, int c, int r);
        segment_id_t s;
        s.line = 4'(l);
        s.col  = 4'(c);
        s.row  = 2'(r);
        return int'(s);
    endfunction

    task automatic step();
        @(negedge clk);
        if (rand_pix) begin
            has_segment = 1'($urandom);
            if (m_mode == 2 && $urandom_range(0, 1) == 1)
                segment_id = ID_BITS'(m_swc / 2);
            else
                segment_id = ID_BITS'($urandom);
        end
    endtask

    task automatic lookup(input string nm, input int id, input bit has, input int exp);
        segment_id = ID_BITS'(id);
        has_segment = has;
        step();
        step();
        check(nm, segment_level, exp);
        check({nm, "_en"}, segment_en, int'(exp != 0));
    endtask

    task automatic frame(input int gap, input logic [NUM_SEGS-1:0] live2,
                         input bit chg, input string nm);
        int k;
        int cnt;
        k = 0;
        cnt = 0;
        vblank_int = 1'b1;
        do begin
            step();
            k++;
            if (sweep_busy) cnt++;
            if (k == 3 || k == gap + 3) vblank_int = 1'b0;
            if (k == gap) begin
                vblank_int = 1'b1;
                seg_live = live2;
            end
            if (chg && k == 700) begin
                fade_rise = 4'($urandom);
                fade_fall = 4'($urandom);
                fade_en = 1'($urandom);
            end
        end while (sweep_busy && k < 5000);
        check({nm, "_sweep_len"}, cnt, 2 * NUM_SEGS);
    endtask

    int fade_exp [6] = '{15, 11, 7, 3, 0, 0};
    int rise_exp [4] = '{6, 12, 15, 15};

    initial begin
        int k;
        int cnt;
        int a;
        int b;
        logic [NUM_SEGS-1:0] l2;
        a = sid(2, 3, 1);
        b = sid(2, 3, 0);
        check("id_pack", a, 141);
        rand_pix = 1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        cnt = 0;
        k = 0;
        while (sweep_busy && k < 5000) begin
            cnt++;
            step();
            k++;
        end
        check("clear_len", cnt, NUM_SEGS);
        check("ovr_reset", overrun, 0);
        rand_pix = 0;
        has_segment = 1'b0;

        fade_en = 1'b0;
        seg_live = '0;
        seg_live[a] = 1'b1;
        frame(0, '0, 0, "binary");
        lookup("bin_on", a, 1, 15);
        lookup("bin_off", b, 1, 0);

        fade_en = 1'b1;
        fade_rise = 4'd15;
        fade_fall = 4'd4;
        for (int i = 0; i < 6; i++) begin
            seg_live = '0;
            if (i == 0) seg_live[a] = 1'b1;
            frame(0, '0, 0, "fade");
            lookup($sformatf("fade%0d", i), a, 1, fade_exp[i]);
        end

        fade_rise = 4'd6;
        seg_live = '0;
        seg_live[a] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            frame(0, '0, 0, "rise");
            lookup($sformatf("rise%0d", i), a, 1, rise_exp[i]);
        end
        lookup("no_seg", a, 0, 0);

        check("ovr_pre", overrun, 0);
        fade_en = 1'b0;
        seg_live = '0;
        seg_live[a] = 1'b1;
        l2 = '0;
        l2[b] = 1'b1;
        frame(500, l2, 0, "ovr");
        check("ovr_set", overrun, 1);
        lookup("ovr_keep", a, 1, 15);
        lookup("ovr_nosnap", b, 1, 0);

        rand_pix = 1;
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < NUM_SEGS; i += 32) seg_live[i+:32] = $urandom;
            fade_en = 1'($urandom);
            fade_rise = 4'($urandom);
            fade_fall = 4'($urandom);
            frame(0, '0, 1, "rnd");
            repeat (20) step();
        end
        rand_pix = 0;
        has_segment = 1'b0;
        repeat (4) step();
        check("ovr_sticky", overrun, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
